mem_bus_ctrl: RTL and testbench

- Parametrised single-clock memory bus controller between the mcu core and the memory block.
- Replaces the fixed two-phase M_clk/P_clk scheme with a request/ready handshake, programmable wait states and a write-to-read bus turnaround.
- Splits the shared bidirectional data path into separate in/out buses plus an output enable for the bus block.

---
 rtl/mem_bus_ctrl_if.sv | 32 +++
 rtl/mem_bus_ctrl.sv | 106 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Core-side request/ready handshake and split memory data path of the bus controller.
// Handshake: the core raises req with we/addr/wdata; they are taken only while the controller is idle, and ready pulses for one cycle when that transfer completes.
interface mem_bus_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 5
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          mem_oe;
  logic [DW-1:0] mem_din;
  logic          mem_read;
  logic          mem_write;

  // Controller side.
  modport slave (
    input  req, we, addr, wdata, mem_din,
    output ready, rdata, busy, mem_addr, mem_dout, mem_oe, mem_read, mem_write
  );

  // Core plus memory side.
  modport master (
    output req, we, addr, wdata, mem_din,
    input  ready, rdata, busy, mem_addr, mem_dout, mem_oe, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-clock memory bus controller: latches one core request, runs SETUP/ACCESS
// with programmable wait states, optionally inserts a write-to-read turnaround cycle.
module mem_bus_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int WAIT    = 1,
  parameter int TURN_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_ctrl_if.slave    bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          last_wr;
  logic [3:0]    cnt;

  assign state_dbg = state;

  // All bus outputs are registered: each transition loads the values of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_wr       <= 1'b0;
      cnt           <= 4'd0;
      bus.ready     <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_dout  <= '0;
      bus.mem_oe    <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q         <= bus.we;
            addr_q       <= bus.addr;
            wdata_q      <= bus.wdata;
            cnt          <= WAIT_CNT;
            bus.busy     <= 1'b1;
            bus.mem_addr <= bus.addr;
            // A read right after a completed write gets one idle cycle so the data path can turn around.
            if ((TURN_EN != 0) && last_wr && !bus.we) begin
              state <= TURN;
            end else begin
              state        <= SETUP;
              bus.mem_oe   <= bus.we;
              bus.mem_read <= !bus.we;
              if (bus.we) bus.mem_dout <= bus.wdata;
            end
          end
        end
        TURN: begin
          state        <= SETUP;
          bus.mem_addr <= addr_q;
          bus.mem_oe   <= we_q;
          bus.mem_read <= !we_q;
          if (we_q) bus.mem_dout <= wdata_q;
        end
        SETUP: begin
          state         <= ACCESS;
          bus.mem_write <= we_q;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state         <= DONE;
            bus.ready     <= 1'b1;
            bus.mem_oe    <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (!we_q) bus.rdata <= bus.mem_din;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b0;
          bus.busy  <= 1'b0;
          last_wr   <= we_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: four builds (WAIT/TURN_EN variants) sharing one memory model,
// directed scenarios plus randomized transfers checked against a transfer-level model.
module tb_mem_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a [4];
  logic       we;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] mem_din;

  logic       ready_a     [4];
  logic [7:0] rdata_a     [4];
  logic       busy_a      [4];
  logic [4:0] mem_addr_a  [4];
  logic [7:0] mem_dout_a  [4];
  logic       mem_oe_a    [4];
  logic       mem_read_a  [4];
  logic       mem_write_a [4];
  logic [2:0] state_a     [4];

  // Model parameters of each build: 0 = WAIT 1/TURN 1, 1 = WAIT 0, 2 = WAIT 15, 3 = WAIT 1/no TURN.
  int wait_m [4] = '{1, 0, 15, 1};
  bit turn_m [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit last_wr_m [4];

  int checks = 0;
  int errors = 0;
  int act = 0;
  bit prev_hold = 1'b0;
  bit ovr = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  logic [7:0]  mem_arr [32];
  logic [31:0] mem_vld = 32'h0;
  logic [7:0]  exp_mem [32];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gen_dut
      localparam int WAIT_G = (g == 1) ? 0 : (g == 2) ? 15 : 1;
      localparam int TURN_G = (g == 3) ? 0 : 1;
      mem_bus_ctrl_if #(.DW(8), .AW(5)) bus ();
      assign bus.req     = req_a[g];
      assign bus.we      = we;
      assign bus.addr    = addr;
      assign bus.wdata   = wdata;
      assign bus.mem_din = mem_din;
      assign ready_a[g]     = bus.ready;
      assign rdata_a[g]     = bus.rdata;
      assign busy_a[g]      = bus.busy;
      assign mem_addr_a[g]  = bus.mem_addr;
      assign mem_dout_a[g]  = bus.mem_dout;
      assign mem_oe_a[g]    = bus.mem_oe;
      assign mem_read_a[g]  = bus.mem_read;
      assign mem_write_a[g] = bus.mem_write;
      mem_bus_ctrl #(.DW(8), .AW(5), .WAIT(WAIT_G), .TURN_EN(TURN_G)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_a[g])
      );
    end
  endgenerate

  function automatic logic [7:0] init_val(input logic [4:0] a);
    return (a == 5'h03) ? 8'hA5 : {3'b011, a};
  endfunction

  // Memory block seen by the active build.
  always @(posedge clk) begin
    if (mem_write_a[act]) begin
      mem_arr[mem_addr_a[act]] <= mem_dout_a[act];
      mem_vld[mem_addr_a[act]] <= 1'b1;
    end
  end

  assign mem_din = ovr ? ovr_val :
                   (mem_vld[mem_addr_a[act]] ? mem_arr[mem_addr_a[act]] : init_val(mem_addr_a[act]));

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return {3'b000, ready_a[d], busy_a[d], rdata_a[d], mem_addr_a[d], mem_dout_a[d],
            mem_oe_a[d], mem_read_a[d], mem_write_a[d], state_a[d]};
  endfunction

  // One transfer on build d; sa/sw are what addr/wdata change to while the build is busy.
  task automatic xfer(input int d, input bit w, input logic [4:0] a, input logic [7:0] wd,
                      input bit hold, input bit ovr_rand, input logic [4:0] sa, input logic [7:0] sw);
    int k, gap, nrd, nwr, noe, nturn, nbad, exp_lat;
    bit done, exp_turn;
    logic [7:0] last_v;
    act      = d;
    exp_turn = turn_m[d] && last_wr_m[d] && !w;
    exp_lat  = wait_m[d] + 3 + (exp_turn ? 1 : 0);
    we = w; addr = a; wdata = wd; req_a[d] = 1'b1;
    last_v = 8'h00;
    if (ovr_rand) begin
      ovr = 1'b1; ovr_val = 8'($urandom); last_v = ovr_val;
    end
    gap = 0;
    while (busy_a[d] && gap < 40) begin
      @(negedge clk); gap++;
    end
    chk("accept_gap", gap, prev_hold ? 1 : 0);
    @(posedge clk);
    k = 0; done = 1'b0; nrd = 0; nwr = 0; noe = 0; nturn = 0; nbad = 0;
    while (!done && k < 40) begin
      @(negedge clk); k++;
      if (k == 1) begin
        if (!busy_a[d]) nbad++;
        if (!hold) req_a[d] = 1'b0;
        addr = sa; wdata = sw;
      end
      if (mem_read_a[d]) nrd++;
      if (mem_write_a[d]) nwr++;
      if (mem_oe_a[d]) noe++;
      if (mem_read_a[d] && (mem_write_a[d] || mem_oe_a[d])) nbad++;
      if ((mem_read_a[d] || mem_write_a[d] || mem_oe_a[d]) && mem_addr_a[d] != a) nbad++;
      if (mem_oe_a[d] && mem_dout_a[d] != wd) nbad++;
      if (busy_a[d] && !ready_a[d] && !mem_read_a[d] && !mem_write_a[d] && !mem_oe_a[d]) nturn++;
      if (ready_a[d]) done = 1'b1;
      else if (ovr_rand) begin
        ovr_val = 8'($urandom); last_v = ovr_val;
      end
    end
    chk("latency", k, exp_lat);
    chk("turn_cycles", nturn, exp_turn ? 1 : 0);
    chk("protocol_bad_cycles", nbad, 0);
    if (w) begin
      chk("wr_write_cycles", nwr, wait_m[d] + 1);
      chk("wr_oe_cycles", noe, wait_m[d] + 2);
      chk("wr_read_cycles", nrd, 0);
      exp_mem[a] = wd;
    end else begin
      chk("rd_read_cycles", nrd, wait_m[d] + 2);
      chk("rd_wr_oe_cycles", nwr + noe, 0);
      chk("rdata", rdata_a[d], ovr_rand ? last_v : exp_mem[a]);
    end
    last_wr_m[d] = w;
    ovr = 1'b0;
    prev_hold = hold;
    if (!hold) begin
      @(negedge clk);
      chk("busy_after", {busy_a[d], ready_a[d]}, 2'b00);
      if (!w) chk("rdata_held", rdata_a[d], ovr_rand ? last_v : exp_mem[a]);
    end
  endtask

  initial begin
    int nb, nr, d;
    bit w, h;
    for (int i = 0; i < 32; i++) exp_mem[i] = init_val(5'(i));
    for (int i = 0; i < 4; i++) begin req_a[i] = 1'b0; last_wr_m[i] = 1'b0; end
    reset = 1'b0; we = 1'b0; addr = 5'h00; wdata = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("reset_outputs", outs(i), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Basic read and write on WAIT=1.
    xfer(0, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h0A, 8'h55);
    xfer(0, 1'b1, 5'h1F, 8'h3C, 1'b0, 1'b0, 5'h01, 8'h00);
    chk("wr_mem_1f", mem_arr[31], 8'h3C);

    // Write then read with req held: TURN build versus no-TURN build.
    xfer(0, 1'b1, 5'h02, 8'h6D, 1'b1, 1'b0, 5'h07, 8'h99);
    xfer(0, 1'b0, 5'h02, 8'h00, 1'b0, 1'b0, 5'h07, 8'h99);
    xfer(3, 1'b1, 5'h02, 8'h4E, 1'b1, 1'b0, 5'h07, 8'h99);
    xfer(3, 1'b0, 5'h02, 8'h00, 1'b0, 1'b0, 5'h07, 8'h99);

    // WAIT=0 and WAIT=15 reads with mem_din changing every cycle.
    xfer(1, 1'b0, 5'h05, 8'h00, 1'b0, 1'b1, 5'h06, 8'h00);
    xfer(2, 1'b0, 5'h06, 8'h00, 1'b0, 1'b1, 5'h05, 8'h00);

    // Inputs changed while busy must not leak into the transfer or start another one.
    xfer(0, 1'b1, 5'h04, 8'h11, 1'b0, 1'b0, 5'h10, 8'hFF);
    chk("scramble_mem04", mem_arr[4], 8'h11);
    chk("scramble_mem10_untouched", mem_vld[16], 1'b0);
    nb = 0;
    repeat (4) begin @(negedge clk); if (busy_a[0]) nb++; end
    chk("no_second_transfer", nb, 0);

    // Randomized traffic on the TURN and no-TURN builds.
    d = 0;
    for (int i = 0; i < 24; i++) begin
      if (!prev_hold) d = ($urandom_range(0, 1) != 0) ? 3 : 0;
      w = ($urandom_range(0, 1) != 0);
      h = (i < 23) ? ($urandom_range(0, 2) == 0) : 1'b0;
      xfer(d, w, 5'($urandom_range(0, 15)), 8'($urandom), h, 1'b0,
           5'($urandom_range(0, 31)), 8'($urandom));
    end

    // Reset in the middle of ACCESS of a write.
    act = 0; we = 1'b1; addr = 5'h1E; wdata = 8'($urandom); req_a[0] = 1'b1;
    nb = 0;
    while (busy_a[0] && nb < 40) begin @(negedge clk); nb++; end
    @(posedge clk);
    @(negedge clk); req_a[0] = 1'b0;
    @(negedge clk);
    chk("abort_in_access", {mem_write_a[0], state_a[0]}, {1'b1, 3'd3});
    #2 reset = 1'b0;
    #1 chk("abort_async_outputs", outs(0), 32'h0);
    nr = 0;
    repeat (2) begin @(negedge clk); if (ready_a[0]) nr++; end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) last_wr_m[i] = 1'b0;
    prev_hold = 1'b0;
    repeat (2) begin @(negedge clk); if (ready_a[0]) nr++; end
    chk("abort_no_ready", nr, 0);
    chk("abort_idle", {busy_a[0], state_a[0]}, 4'h0);
    xfer(0, 1'b0, 5'h05, 8'h00, 1'b0, 1'b0, 5'h1E, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
